// File: rtl/cnn_param_loader.sv
// Purpose: loads CNN parameter regions (image, conv kernels, FC weights) from a word stream and serves reads.
// Latency: a written word is readable the next cycle; reads return one cycle after rd_en.
// Backpressure: in_ready is high for the whole LOAD state (one word per cycle); reads never stall.
module cnn_param_loader #(
  parameter int DATA_W   = 32,
  parameter int IMG_DIM  = 28,
  parameter int KSIZE    = 5,
  parameter int N_KERNEL = 8,
  parameter int FC_LEN   = 1152,
  parameter int N_CLASS  = 10,
  parameter int ADDR_W   = 14
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [1:0]                        region,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_W-1:0]                 in_data,
  input  logic                              in_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err,
  output logic [2:0]                        region_valid,
  input  logic                              rd_en,
  input  logic [1:0]                        rd_region,
  input  logic [ADDR_W-1:0]                 rd_addr,
  output logic [DATA_W-1:0]                 rd_data,
  output logic                              rd_valid,
  output logic [DATA_W*IMG_DIM*IMG_DIM-1:0] img_f
);

  // Region sizes: image is row-major i*IMG_DIM+j, conv is k*KSIZE*KSIZE+r*KSIZE+c,
  // fc is class*FC_LEN+i. The stream order is simply the linear address order.
  localparam int IMG_N  = IMG_DIM * IMG_DIM;
  localparam int CONV_N = N_KERNEL * KSIZE * KSIZE;
  localparam int FC_N   = N_CLASS * FC_LEN;

  localparam int IMG_AW  = $clog2(IMG_N);
  localparam int CONV_AW = $clog2(CONV_N);
  localparam int FC_AW   = $clog2(FC_N);

  // Highest legal address of each region (size-1), in counter width.
  localparam logic [ADDR_W-1:0] IMG_LAST  = ADDR_W'(IMG_N - 1);
  localparam logic [ADDR_W-1:0] CONV_LAST = ADDR_W'(CONV_N - 1);
  localparam logic [ADDR_W-1:0] FC_LAST   = ADDR_W'(FC_N - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOAD = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [1:0]        sel_q, sel_d;
  logic [2:0]        rv_q, rv_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              acc;
  logic [ADDR_W-1:0] cur_last;
  logic [ADDR_W-1:0] rd_last;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;

  // The image region doubles as the flattened img_f bus, so it is a resettable
  // packed register; conv and fc are plain (unreset) RAM arrays.
  logic [IMG_N-1:0][DATA_W-1:0] img_q;
  logic [DATA_W-1:0]            conv_mem [CONV_N];
  logic [DATA_W-1:0]            fc_mem   [FC_N];

  function automatic logic [ADDR_W-1:0] last_of(input logic [1:0] r);
    case (r)
      2'd0:    return IMG_LAST;
      2'd1:    return CONV_LAST;
      2'd2:    return FC_LAST;
      default: return '0;
    endcase
  endfunction

  assign in_ready     = (state_q == LOAD);
  assign busy         = (state_q == LOAD);
  assign acc          = in_ready && in_valid;
  assign cur_last     = last_of(sel_q);
  assign rd_last      = last_of(rd_region);
  assign done         = done_q;
  assign err          = err_q;
  assign region_valid = rv_q;
  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign img_f        = img_q;

  // Control state register; reset aborts any load in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sel_q   <= '0;
      rv_q    <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      rv_q    <= rv_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: start only honoured in IDLE; load ends on the last slot or an early in_last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    rv_d    = rv_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (region != 2'd3) begin
            state_d      = LOAD;
            sel_d        = region;
            cnt_d        = '0;
            rv_d[region] = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (acc) begin
          if (cnt_q == cur_last) begin
            // Region full: in_last is irrelevant on this word.
            state_d     = IDLE;
            rv_d[sel_q] = 1'b1;
            done_d      = 1'b1;
          end else if (in_last) begin
            // Stream ended short: region stays marked stale.
            state_d = IDLE;
            err_d   = 1'b1;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Image storage write; also the registered img_f bus.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      img_q <= '0;
    end else if (acc && sel_q == 2'd0) begin
      img_q[cnt_q[IMG_AW-1:0]] <= in_data;
    end
  end

  // Conv and FC RAM writes; contents survive reset and are qualified by region_valid.
  always_ff @(posedge clk) begin
    if (acc && sel_q == 2'd1) conv_mem[cnt_q[CONV_AW-1:0]] <= in_data;
    if (acc && sel_q == 2'd2) fc_mem[cnt_q[FC_AW-1:0]]     <= in_data;
  end

  // Registered read port: old data on a same-cycle write, zero for bad region/address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        if (rd_region == 2'd3 || rd_addr > rd_last) begin
          rd_data_q <= '0;
        end else begin
          case (rd_region)
            2'd0:    rd_data_q <= img_q[rd_addr[IMG_AW-1:0]];
            2'd1:    rd_data_q <= conv_mem[rd_addr[CONV_AW-1:0]];
            2'd2:    rd_data_q <= fc_mem[rd_addr[FC_AW-1:0]];
            default: rd_data_q <= '0;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_cnn_param_loader.sv
// Purpose: directed self-checking bench for cnn_param_loader.
// Latency: inputs driven on negedges, outputs sampled on the following negedge.
// Backpressure: word sends wait on in_ready with a bounded cycle budget.
module tb_cnn_param_loader;
  localparam int DATA_W   = 32;
  localparam int IMG_DIM  = 28;
  localparam int KSIZE    = 5;
  localparam int N_KERNEL = 8;
  localparam int FC_LEN   = 1152;
  localparam int N_CLASS  = 10;
  localparam int ADDR_W   = 14;

  logic                              clk = 1'b0;
  logic                              rst;
  logic                              start;
  logic [1:0]                        region;
  logic                              in_valid;
  logic                              in_ready;
  logic [DATA_W-1:0]                 in_data;
  logic                              in_last;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic [2:0]                        region_valid;
  logic                              rd_en;
  logic [1:0]                        rd_region;
  logic [ADDR_W-1:0]                 rd_addr;
  logic [DATA_W-1:0]                 rd_data;
  logic                              rd_valid;
  logic [DATA_W*IMG_DIM*IMG_DIM-1:0] img_f;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int rdy_cnt   = 0;

  logic [31:0] d;
  logic        v;

  cnn_param_loader #(
    .DATA_W(DATA_W), .IMG_DIM(IMG_DIM), .KSIZE(KSIZE), .N_KERNEL(N_KERNEL),
    .FC_LEN(FC_LEN), .N_CLASS(N_CLASS), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .region(region),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .busy(busy), .done(done), .err(err), .region_valid(region_valid),
    .rd_en(rd_en), .rd_region(rd_region), .rd_addr(rd_addr),
    .rd_data(rd_data), .rd_valid(rd_valid), .img_f(img_f)
  );

  always #5 clk = ~clk;

  // Pulse and handshake counters, sampled on the pre-edge values.
  always @(posedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (in_ready) rdy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [31:0] img_el(input int i, input int j);
    return img_f[DATA_W*(IMG_DIM*i+j) +: DATA_W];
  endfunction

  // Called at a negedge; returns at the negedge after the word is accepted.
  task automatic send(input logic [31:0] w, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_data  = w;
    in_last  = last;
    while (!in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) chk("in_ready_wait", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic start_load(input logic [1:0] r);
    start  = 1'b1;
    region = r;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] r, input int a, output logic [31:0] dat, output logic vld);
    rd_en     = 1'b1;
    rd_region = r;
    rd_addr   = ADDR_W'(a);
    @(negedge clk);
    dat   = rd_data;
    vld   = rd_valid;
    rd_en = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; region = '0; in_valid = 1'b0; in_data = '0;
    in_last = 1'b0; rd_en = 1'b1; rd_region = '0; rd_addr = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 0);
    chk("rst_done", {31'b0, done}, 0);
    chk("rst_err", {31'b0, err}, 0);
    chk("rst_region_valid", {29'b0, region_valid}, 0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_img_f_zero", {31'b0, (img_f == '0)}, 1);
    rd_en = 1'b0;
    rst   = 1'b1;
    repeat (2) @(negedge clk);

    // Conv load 0..199 back-to-back
    rdy_cnt = 0; done_cnt = 0; err_cnt = 0;
    start_load(2'd1);
    chk("conv_busy", {31'b0, busy}, 1);
    for (int n = 0; n < 200; n++) send(32'(n), 1'b0);
    in_valid = 1'b0;
    chk("conv_done_pulse", {31'b0, done}, 1);
    chk("conv_busy_end", {31'b0, busy}, 0);
    @(negedge clk);
    chk("conv_done_one_cycle", {31'b0, done}, 0);
    @(negedge clk);
    chk("conv_ready_cycles", rdy_cnt, 200);
    chk("conv_done_count", done_cnt, 1);
    chk("conv_region_valid", {29'b0, region_valid}, 32'b010);
    rd(2'd1, 137, d, v);
    chk("conv_rd137_data", d, 137);
    chk("conv_rd137_valid", {31'b0, v}, 1);
    @(negedge clk);
    chk("rd_valid_drops", {31'b0, rd_valid}, 0);

    // Image load, word n = -n
    start_load(2'd0);
    for (int n = 0; n < 784; n++) begin
      send(32'(-n), 1'b0);
      if (n == 10) chk("img_f_next_cycle", img_el(0, 10), 32'hFFFF_FFF6);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("img_27_27", img_el(27, 27), 32'hFFFF_FCF1);
    chk("img_0_1", img_el(0, 1), 32'hFFFF_FFFF);
    chk("img_0_0", img_el(0, 0), 0);
    chk("img_region_valid", {29'b0, region_valid}, 32'b011);

    // Illegal region and out-of-range reads
    err_cnt = 0;
    start_load(2'd3);
    chk("r3_err_pulse", {31'b0, err}, 1);
    chk("r3_busy", {31'b0, busy}, 0);
    @(negedge clk);
    chk("r3_err_one_cycle", {31'b0, err}, 0);
    chk("r3_region_valid", {29'b0, region_valid}, 32'b011);
    rd(2'd2, 11520, d, v);
    chk("fc_oob_data", d, 0);
    chk("fc_oob_valid", {31'b0, v}, 1);
    rd(2'd0, 783, d, v);
    chk("img_rd783", d, 32'hFFFF_FCF1);
    rd(2'd1, 200, d, v);
    chk("conv_oob_data", d, 0);
    rd(2'd3, 5, d, v);
    chk("rd_region3_data", d, 0);
    chk("rd_region3_valid", {31'b0, v}, 1);
    rd(2'd0, 1, d, v);
    chk("img_rd1", d, 32'hFFFF_FFFF);

    // Conv reload with random gaps and ignored start pulses; read-before-write at addr 5
    done_cnt = 0; err_cnt = 0;
    start_load(2'd1);
    for (int n = 0; n < 200; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      if (gap != 0) in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        if ($urandom_range(0, 1) == 1) begin
          start  = 1'b1;
          region = (n % 2 == 0) ? 2'd0 : 2'd3;
        end
        @(negedge clk);
        start = 1'b0;
      end
      if (n == 5) begin
        rd_en = 1'b1; rd_region = 2'd1; rd_addr = ADDR_W'(5);
      end
      send(32'(1000 + n), 1'b0);
      if (n == 5) begin
        chk("read_before_write", rd_data, 5);
        rd_en = 1'b0;
      end
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rand_done_count", done_cnt, 1);
    chk("rand_err_count", err_cnt, 0);
    chk("rand_region_valid", {29'b0, region_valid}, 32'b011);
    for (int n = 0; n < 200; n++) begin
      rd(2'd1, n, d, v);
      chk("rand_readback", d, 32'(1000 + n));
    end
    chk("rand_img_intact", img_el(27, 27), 32'hFFFF_FCF1);

    // FC load cut short by in_last on word 500
    done_cnt = 0; err_cnt = 0;
    start_load(2'd2);
    for (int n = 0; n <= 500; n++) send(32'(n), n == 500);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("short_err_pulse", {31'b0, err}, 1);
    chk("short_busy", {31'b0, busy}, 0);
    repeat (2) @(negedge clk);
    chk("short_err_count", err_cnt, 1);
    chk("short_done_count", done_cnt, 0);
    chk("short_region_valid", {29'b0, region_valid}, 32'b011);
    rd(2'd2, 500, d, v);
    chk("short_last_written", d, 500);
    start_load(2'd2);
    chk("restart_busy", {31'b0, busy}, 1);

    // Reset after 50 accepted words, then a full FC load
    for (int n = 0; n < 50; n++) send(32'd7, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_region_valid", {29'b0, region_valid}, 0);
    chk("arst_in_ready", {31'b0, in_ready}, 0);
    chk("arst_img_cleared", img_el(27, 27), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    rdy_cnt = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", {31'b0, busy}, 0);
    chk("post_rst_no_accept", rdy_cnt, 0);
    in_valid = 1'b0;
    done_cnt = 0;
    start_load(2'd2);
    for (int n = 0; n < 11520; n++) send(32'(3 * n + 7), 1'b0);
    in_valid = 1'b0;
    chk("fc_done_pulse", {31'b0, done}, 1);
    repeat (2) @(negedge clk);
    chk("fc_done_count", done_cnt, 1);
    chk("fc_region_valid", {29'b0, region_valid}, 32'b100);
    rd(2'd2, 11519, d, v);
    chk("fc_rd11519", d, 34564);
    rd(2'd2, 49, d, v);
    chk("fc_rd49", d, 154);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/cnn_param_loader.md
CNN_PARAM_LOADER -- requirements
Module: cnn_param_loader

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning), one per line:
- DATA_W, 32, signed word width
- IMG_DIM, 28, image side length
- KSIZE, 5, conv kernel side length
- N_KERNEL, 8, number of conv kernels
- FC_LEN, 1152, FC inputs per class
- N_CLASS, 10, number of FC classes
- ADDR_W, 14, address width, at least clog2 of the largest region size
REQ-002 Region sizes SHALL be:
- region 0, image: IMG_DIM*IMG_DIM
- region 1, conv: N_KERNEL*KSIZE*KSIZE
- region 2, fc: N_CLASS*FC_LEN
REQ-003 The block SHALL have these ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- rst, in, 1, reset, asynchronous, active-low
- start, in, 1, begin a load
- region, in, 2, region selected at start
- in_valid, in, 1, input word valid
- in_ready, out, 1, loader accepts a word
- in_data, in, DATA_W, signed input word
- in_last, in, 1, final word of the stream
- busy, out, 1, load in progress
- done, out, 1, one-cycle completion pulse
- err, out, 1, one-cycle error pulse
- region_valid, out, 3, per-region loaded flag
- rd_en, in, 1, read request
- rd_region, in, 2, read region
- rd_addr, in, ADDR_W, read address
- rd_data, out, DATA_W, read data
- rd_valid, out, 1, rd_data valid
- img_f, out, DATA_W*IMG_DIM*IMG_DIM, flattened image bus
REQ-004 One clock (clk); reset rst asynchronous, active-low.

Function
REQ-005 FSM states SHALL be IDLE and LOAD; busy SHALL equal (state==LOAD).
REQ-006 IDLE, start=1 with region<=2: go to LOAD, latch region, clear word counter, clear region_valid[region].
REQ-007 IDLE, start=1 with region==3: pulse err next cycle, stay IDLE, no other state change.
REQ-008 start SHALL be ignored in LOAD.
REQ-009 in_ready SHALL be 1 only in LOAD; a word is accepted when in_valid and in_ready are both 1.
REQ-010 On each accepted word, in_data SHALL be written to mem[region][cnt], then cnt increments.
REQ-011 Accepted word with cnt==size-1: return to IDLE, set region_valid[region], pulse done for exactly one cycle on the following cycle; in_last SHALL be don't-care on that word.
REQ-012 Accepted word with in_last=1 and cnt<size-1: write the word, return to IDLE, pulse err, leave region_valid[region]=0.
REQ-013 The loader SHALL accept at most one word per cycle, with no bubbles while in_valid is held (full throughput).
REQ-014 Conv address layout SHALL be k*KSIZE*KSIZE + r*KSIZE + c; fc layout SHALL be class*FC_LEN + i; image layout SHALL be i*IMG_DIM + j (row-major).
REQ-015 On every image-region write, img_f[DATA_W*(IMG_DIM*i+j) +: DATA_W] SHALL update the cycle after acceptance.
REQ-016 Reads SHALL have 1-cycle latency: rd_data and rd_valid are registered; rd_valid equals rd_en delayed one cycle.
REQ-017 A read to rd_region==3, or with rd_addr>=size, SHALL return rd_data=0 with rd_valid=1.
REQ-018 A read and write to the same location in the same cycle SHALL return the old data (read-before-write).
REQ-019 Reads SHALL be permitted in any state and SHALL never stall loading.
REQ-020 Arithmetic: data SHALL be stored bit-exact with no sign extension or truncation; cnt SHALL be ADDR_W bits wide and never exceed size-1.

Reset
REQ-021 While rst=0, the block SHALL hold: state=IDLE, cnt=0, busy=0, done=0, err=0, in_ready=0, region_valid=0, rd_valid=0, rd_data=0, img_f=0.
REQ-022 Reset asserted mid-LOAD SHALL abort the load and accept no further words.
REQ-023 Memory arrays are not reset; region_valid=0 marks their contents stale.

Verification
REQ-024 Load region 1 with 200 words valued 0..199 back-to-back -> in_ready high 200 cycles, done pulses once, region_valid=3'b010; read addr 137 -> rd_data=137 one cycle later.
REQ-025 Load region 0 with word n = -n (784 words) -> img_f element (27,27) = -783 (0xFFFFFCF1) and element (0,1) = -1; region_valid[0]=1.
REQ-026 Load region 2 with in_last asserted on word 500 -> err pulses, busy drops, region_valid[2]=0, a new start is accepted afterwards.
REQ-027 start with region=3 -> err pulse, busy stays 0; rd_region=2, rd_addr=11520 -> rd_data=0, rd_valid=1.
REQ-028 Randomly toggle in_valid during a region-1 load -> exactly 200 words written, in stream order; start pulses during the load have no effect.
REQ-029 Drop rst to 0 after 50 accepted words of a region-2 load -> busy=0 and region_valid=0 immediately; after rst=1 a full region-2 load completes with done.
